mem_access_stage: RTL and testbench

- Stage directly downstream of the ALU.
- Consumes the ALU result as an effective address for LDB/LDW/STB/STW and runs a req/ack transaction on the data-memory port.
- Aligns and extends load data, then presents one writeback record per accepted instruction.
- Non-memory opcodes pass through to writeback with one cycle of latency.

---
 rtl/mem_access_stage_if.sv | 41 ++++
 rtl/mem_access_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_stage_if : upstream, data-memory and writeback bundle          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface mem_access_stage_if #(
  parameter int OP_W = 6
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_op;
  logic [31:0]     in_result;
  logic [31:0]     in_store_data;
  logic [4:0]      in_rd;
  logic            mem_req;
  logic            mem_we;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_be;
  logic            mem_ack;
  logic [31:0]     mem_rdata;
  logic            wb_valid;
  logic            wb_ready;
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [31:0]     wb_data;
  logic            wb_err;

  modport master (
    input  in_valid, in_op, in_result, in_store_data, in_rd, mem_ack, mem_rdata, wb_ready,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output wb_valid, wb_we, wb_rd, wb_data, wb_err
  );

  modport slave (
    output in_valid, in_op, in_result, in_store_data, in_rd, mem_ack, mem_rdata, wb_ready,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  wb_valid, wb_we, wb_rd, wb_data, wb_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_stage : post-ALU load/store stage with req/ack memory port     |
// | Optional: MEM_ALIGN_CHECK_EN faults misaligned word accesses.             |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int OP_W    = 6
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mem_access_stage_if.master bus
);
  localparam int c_cnt_w = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT - 1);
  localparam logic [OP_W-1:0] c_op_or  = OP_W'(4);
  localparam logic [OP_W-1:0] c_op_ldb = OP_W'(10);
  localparam logic [OP_W-1:0] c_op_ldw = OP_W'(11);
  localparam logic [OP_W-1:0] c_op_stb = OP_W'(12);
  localparam logic [OP_W-1:0] c_op_stw = OP_W'(13);
  localparam logic [OP_W-1:0] c_op_mov = OP_W'(14);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t               r_state, w_nx_state;
  logic [c_cnt_w-1:0]   r_cnt, w_nx_cnt;
  logic                 r_is_ldb, w_nx_is_ldb;
  logic [1:0]           r_lane, w_nx_lane;
  logic                 r_mem_req, w_nx_mem_req;
  logic                 r_mem_we, w_nx_mem_we;
  logic [31:0]          r_mem_addr, w_nx_mem_addr;
  logic [31:0]          r_mem_wdata, w_nx_mem_wdata;
  logic [3:0]           r_mem_be, w_nx_mem_be;
  logic                 r_wb_valid, w_nx_wb_valid;
  logic                 r_wb_we, w_nx_wb_we;
  logic [4:0]           r_wb_rd, w_nx_wb_rd;
  logic [31:0]          r_wb_data, w_nx_wb_data;
  logic                 r_wb_err, w_nx_wb_err;

  logic        w_in_ready, w_accept;
  logic        w_is_mem, w_is_word, w_is_store, w_pass_we, w_misalign;
  logic [1:0]  w_lane;
  logic [7:0]  w_ld_byte;
  logic [31:0] w_ld_data;

  assign w_in_ready = (r_state == IDLE) && (!r_wb_valid || bus.wb_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_lane     = bus.in_result[1:0];
  assign w_is_mem   = (bus.in_op >= c_op_ldb) && (bus.in_op <= c_op_stw);
  assign w_is_word  = (bus.in_op == c_op_ldw) || (bus.in_op == c_op_stw);
  assign w_is_store = (bus.in_op == c_op_stb) || (bus.in_op == c_op_stw);
  assign w_pass_we  = (bus.in_op <= c_op_or) || (bus.in_op == c_op_mov);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_is_word && (w_lane != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_ld_byte = bus.mem_rdata[8*r_lane +: 8];
  assign w_ld_data = r_is_ldb ? {{24{w_ld_byte[7]}}, w_ld_byte} : bus.mem_rdata;

  always_comb begin
    w_nx_state     = r_state;
    w_nx_cnt       = r_cnt;
    w_nx_is_ldb    = r_is_ldb;
    w_nx_lane      = r_lane;
    w_nx_mem_req   = r_mem_req;
    w_nx_mem_we    = r_mem_we;
    w_nx_mem_addr  = r_mem_addr;
    w_nx_mem_wdata = r_mem_wdata;
    w_nx_mem_be    = r_mem_be;
    w_nx_wb_valid  = r_wb_valid;
    w_nx_wb_we     = r_wb_we;
    w_nx_wb_rd     = r_wb_rd;
    w_nx_wb_data   = r_wb_data;
    w_nx_wb_err    = r_wb_err;
    case (r_state)
      IDLE: begin
        if (r_wb_valid && bus.wb_ready) w_nx_wb_valid = 1'b0;
        if (w_accept) begin
          w_nx_wb_rd = bus.in_rd;
          if (w_is_mem && !w_misalign) begin
            w_nx_state     = REQ;
            w_nx_cnt       = '0;
            w_nx_mem_req   = 1'b1;
            w_nx_mem_we    = w_is_store;
            w_nx_mem_addr  = {bus.in_result[31:2], 2'b00};
            w_nx_mem_be    = w_is_word ? 4'b1111 : (4'b0001 << w_lane);
            w_nx_mem_wdata = w_is_word ? bus.in_store_data : {4{bus.in_store_data[7:0]}};
            w_nx_is_ldb    = (bus.in_op == c_op_ldb);
            w_nx_lane      = w_lane;
          end else begin
            // Pass-through and alignment faults both retire the ALU result directly.
            w_nx_wb_valid = 1'b1;
            w_nx_wb_data  = bus.in_result;
            w_nx_wb_err   = w_misalign;
            w_nx_wb_we    = w_pass_we && !w_misalign;
            if (w_misalign) w_nx_state = RESP;
          end
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          w_nx_state    = RESP;
          w_nx_mem_req  = 1'b0;
          w_nx_mem_we   = 1'b0;
          w_nx_wb_valid = 1'b1;
          w_nx_wb_err   = 1'b0;
          w_nx_wb_we    = !r_mem_we;
          w_nx_wb_data  = r_mem_we ? 32'h0 : w_ld_data;
        end else if (r_cnt == c_cnt_max) begin
          w_nx_state    = RESP;
          w_nx_mem_req  = 1'b0;
          w_nx_mem_we   = 1'b0;
          w_nx_wb_valid = 1'b1;
          w_nx_wb_err   = 1'b1;
          w_nx_wb_we    = 1'b0;
          w_nx_wb_data  = 32'h0;
        end else begin
          w_nx_cnt = r_cnt + c_cnt_w'(1);
        end
      end
      RESP: begin
        if (bus.wb_ready) begin
          w_nx_wb_valid = 1'b0;
          w_nx_state    = IDLE;
        end
      end
      default: w_nx_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_is_ldb    <= 1'b0;
      r_lane      <= 2'b00;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_mem_be    <= 4'h0;
      r_wb_valid  <= 1'b0;
      r_wb_we     <= 1'b0;
      r_wb_rd     <= 5'h0;
      r_wb_data   <= 32'h0;
      r_wb_err    <= 1'b0;
    end else begin
      r_state     <= w_nx_state;
      r_cnt       <= w_nx_cnt;
      r_is_ldb    <= w_nx_is_ldb;
      r_lane      <= w_nx_lane;
      r_mem_req   <= w_nx_mem_req;
      r_mem_we    <= w_nx_mem_we;
      r_mem_addr  <= w_nx_mem_addr;
      r_mem_wdata <= w_nx_mem_wdata;
      r_mem_be    <= w_nx_mem_be;
      r_wb_valid  <= w_nx_wb_valid;
      r_wb_we     <= w_nx_wb_we;
      r_wb_rd     <= w_nx_wb_rd;
      r_wb_data   <= w_nx_wb_data;
      r_wb_err    <= w_nx_wb_err;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.wb_we     = r_wb_we;
  assign bus.wb_rd     = r_wb_rd;
  assign bus.wb_data   = r_wb_data;
  assign bus.wb_err    = r_wb_err;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_access_stage : scoreboard bench with memory responder and model    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mem_access_stage;
  localparam int TIMEOUT = 16;
  localparam int OP_W    = 6;
  localparam int NO_ACK  = 99;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_stage_if #(.OP_W(OP_W)) bus ();

  mem_access_stage #(.TIMEOUT(TIMEOUT), .OP_W(OP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
    bit          chk_data;
    int          lat;
    int          acc;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          delay;
  } mem_exp_t;

  wb_exp_t     wbq[$];
  mem_exp_t    memq[$];
  bit [7:0]    mdl[int unsigned];
  bit [31:0]   ram[int unsigned];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rand_rdy = 1'b0;
  logic        rdy_val = 1'b1;
  bit          ignore_txn = 1'b0;
  bit          inject_ack = 1'b0;
  bit          seen = 1'b0;
  bit          hold_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [7:0] mbyte(input int unsigned a);
    logic [31:0] w;
    if (mdl.exists(a)) return mdl[a];
    w = init_word(a >> 2);
    return w[8*(a%4) +: 8];
  endfunction

  function automatic logic [31:0] rd_word(input int unsigned w);
    return ram.exists(w) ? ram[w] : init_word(w);
  endfunction

  task automatic preload(input int unsigned a, input logic [31:0] w);
    ram[a >> 2] = w;
    for (int i = 0; i < 4; i++) mdl[(a & ~32'd3) + i] = w[8*i +: 8];
  endtask

  // Reference: spec-level view of one instruction, pushed when the handshake is seen.
  task automatic issue(input logic [5:0] op, input logic [31:0] res, input logic [31:0] sd,
                       input logic [4:0] rd, input int d);
    wb_exp_t e;
    mem_exp_t m;
    int n;
    int unsigned a;
    logic [7:0] b;
    bit is_mem, word, store, mis;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_result = res;
    bus.in_store_data = sd; bus.in_rd = rd;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) begin
      chk("accept_timeout", 64'(bus.in_ready), 64'd1);
    end else begin
      is_mem = (op >= 10) && (op <= 13);
      word   = (op == 11) || (op == 13);
      store  = (op == 12) || (op == 13);
      mis    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      mis    = word && (res[1:0] != 2'b00);
`endif
      e.rd = rd; e.acc = cyc; e.err = 1'b0; e.chk_data = 1'b1;
      if (!is_mem) begin
        e.we = (op <= 4) || (op == 14); e.data = res; e.lat = 1;
      end else if (mis) begin
        e.we = 1'b0; e.err = 1'b1; e.data = res; e.lat = 1;
      end else begin
        a = word ? (res & ~32'd3) : res;
        m.we = store; m.addr = res & ~32'd3; m.delay = d;
        m.be = word ? 4'hF : (4'b0001 << res[1:0]);
        m.wdata = word ? sd : {4{sd[7:0]}};
        memq.push_back(m);
        if (d >= TIMEOUT) begin
          e.we = 1'b0; e.err = 1'b1; e.chk_data = 1'b0; e.data = 32'h0; e.lat = TIMEOUT + 1;
        end else begin
          e.lat = d + 2;
          if (store) begin
            e.we = 1'b0; e.chk_data = 1'b0; e.data = 32'h0;
            if (word) for (int i = 0; i < 4; i++) mdl[a + i] = sd[8*i +: 8];
            else mdl[a] = sd[7:0];
          end else begin
            e.we = 1'b1;
            if (word) e.data = {mbyte(a + 3), mbyte(a + 2), mbyte(a + 1), mbyte(a)};
            else begin b = mbyte(a); e.data = {{24{b[7]}}, b}; end
          end
        end
      end
      wbq.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Data-memory responder: acks after the delay chosen at issue time.
  bit       in_txn = 1'b0;
  int       req_cyc = 0;
  mem_exp_t cur_m;
  always begin
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = $urandom;
    if (inject_ack) begin
      bus.mem_ack = 1'b1;
      inject_ack = 1'b0;
    end else if (bus.mem_req) begin
      if (!in_txn) begin
        in_txn = 1'b1; req_cyc = 0;
        if (memq.size() == 0) begin
          chk("unexpected_mem_req", 64'd1, 64'd0);
          cur_m.delay = NO_ACK; cur_m.we = bus.mem_we; cur_m.addr = bus.mem_addr;
          cur_m.be = bus.mem_be; cur_m.wdata = bus.mem_wdata;
        end else begin
          cur_m = memq.pop_front();
        end
      end
      chk("mem_addr", 64'(bus.mem_addr), 64'(cur_m.addr));
      chk("mem_be", 64'(bus.mem_be), 64'(cur_m.be));
      chk("mem_we", 64'(bus.mem_we), 64'(cur_m.we));
      if (cur_m.we) chk("mem_wdata", 64'(bus.mem_wdata), 64'(cur_m.wdata));
      req_cyc++;
      if (cur_m.delay < TIMEOUT && req_cyc == cur_m.delay + 1) begin
        bus.mem_ack = 1'b1;
        if (cur_m.we) begin
          for (int i = 0; i < 4; i++)
            if (cur_m.be[i]) begin
              logic [31:0] w;
              w = rd_word(cur_m.addr >> 2);
              w[8*i +: 8] = cur_m.wdata[8*i +: 8];
              ram[cur_m.addr >> 2] = w;
            end
        end else begin
          bus.mem_rdata = rd_word(cur_m.addr >> 2);
        end
      end
    end else if (in_txn) begin
      in_txn = 1'b0;
      if (!ignore_txn)
        chk("mem_req_cycles", 64'(req_cyc),
            64'((cur_m.delay < TIMEOUT) ? cur_m.delay + 1 : TIMEOUT));
    end
  end

  always begin
    @(posedge clk); #2;
    bus.wb_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
  end

  // Monitor: pops an expectation when a writeback record first appears.
  wb_exp_t     cur_e;
  logic [38:0] held;
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid) begin
      if (hold_chk) chk("wb_stable", 64'({bus.wb_we, bus.wb_err, bus.wb_rd, bus.wb_data}), 64'(held));
      if (!seen) begin
        seen = 1'b1;
        if (wbq.size() == 0) begin
          chk("unexpected_wb_valid", 64'd1, 64'd0);
        end else begin
          cur_e = wbq.pop_front();
          chk("wb_latency", 64'(cyc - cur_e.acc), 64'(cur_e.lat));
          chk("wb_we", 64'(bus.wb_we), 64'(cur_e.we));
          chk("wb_rd", 64'(bus.wb_rd), 64'(cur_e.rd));
          chk("wb_err", 64'(bus.wb_err), 64'(cur_e.err));
          if (cur_e.chk_data) chk("wb_data", 64'(bus.wb_data), 64'(cur_e.data));
        end
      end
      if (!bus.wb_ready) begin
        chk("in_ready_stalled", 64'(bus.in_ready), 64'd0);
        held = {bus.wb_we, bus.wb_err, bus.wb_rd, bus.wb_data};
        hold_chk = 1'b1;
      end else begin
        seen = 1'b0;
        hold_chk = 1'b0;
      end
    end else begin
      hold_chk = 1'b0;
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((wbq.size() != 0 || bus.wb_valid || bus.mem_req) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_timeout", 64'(n < 2000), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ops[20] = '{0, 1, 2, 3, 4, 14, 30, 31, 32, 33, 10, 11, 12, 13, 10, 11, 12, 13, 7, 63};
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_result = '0; bus.in_store_data = '0;
    bus.in_rd = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0; bus.wb_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    chk("rst_mem_be", 64'(bus.mem_be), 64'd0);
    chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
    chk("rst_wb_err", 64'(bus.wb_err), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;

    issue(6'd0, 32'h0000_002A, 32'h0, 5'd5, 0);
    @(negedge clk);
    chk("add_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    preload(32'h1000, 32'h80FF_0000);
    issue(6'd10, 32'h0000_1003, 32'h0, 5'd7, 0);
    issue(6'd12, 32'h0000_2001, 32'h0000_00AB, 5'd3, 1);
    drain();

    rdy_val = 1'b0;
    issue(6'd11, 32'h0000_1000, 32'h0, 5'd9, 3);
    for (int n = 0; n < 50 && !bus.wb_valid; n++) @(negedge clk);
    chk("stall_wb_seen", 64'(bus.wb_valid), 64'd1);
    repeat (2) @(negedge clk);
    rdy_val = 1'b1;
    drain();

    issue(6'd11, 32'h0000_1004, 32'h0, 5'd4, NO_ACK);
    drain();
    issue(6'd11, 32'h0000_1002, 32'h0, 5'd6, 0);
    drain();

    issue(6'd11, 32'h0000_1000, 32'h0, 5'd1, NO_ACK);
    repeat (3) begin @(posedge clk); #1; end
    ignore_txn = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_dropped", 64'(bus.mem_req), 64'd0);
    rst_n = 1'b1;
    wbq.delete(); memq.delete();
    seen = 1'b0; hold_chk = 1'b0;
    @(negedge clk);
    inject_ack = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("late_ack_no_wb", 64'(bus.wb_valid), 64'd0);
    end
    ignore_txn = 1'b0;
    @(posedge clk); #1;

    rand_rdy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      logic [5:0]  op;
      logic [31:0] res;
      int          d;
      op  = 6'(ops[$urandom_range(0, 19)]);
      res = ((op >= 10) && (op <= 13)) ? 32'h3000 + $urandom_range(0, 63) : $urandom;
      if ((op == 11 || op == 13) && $urandom_range(0, 3) != 0) res = res & ~32'd3;
      d   = ($urandom_range(0, 15) == 0) ? NO_ACK : int'($urandom_range(0, 4));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      issue(op, res, $urandom, 5'($urandom), d);
    end
    rand_rdy = 1'b0;
    rdy_val = 1'b1;
    drain();
    chk("queue_empty", 64'(wbq.size() + memq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
